input_debounce: RTL and testbench

Multi-channel synchronizer and debouncer for slow mechanical inputs such as rotary-encoder A/B contacts and push buttons. It sits directly upstream of the quadrature decoder and drives its `A`/`B` inputs with clean, metastability-free levels. It also provides one-cycle rise and fall strobes for edge-driven consumers. All channels are independent and share one clock.

---
 rtl/input_debounce_pkg.sv | 10 +
 rtl/debounce_channel.sv | 82 ++++++++
 rtl/input_debounce.sv | 31 +++
 tb/tb_input_debounce.sv | 128 ++++++++++++
 4 files changed

// File: rtl/input_debounce_pkg.sv
// Shared types for the input debouncer: per-channel settle state.
package input_debounce_pkg;

  // STABLE while the counter is zero, COUNTING while a disagreement is being timed
  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

endpackage : input_debounce_pkg

// File: rtl/debounce_channel.sv
// One debounced channel: synchronizer chain, stability counter, registered level and edge strobes.
module debounce_channel
  import input_debounce_pkg::*;
#(
  parameter int unsigned BOUNCE_LIMIT = 300000,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter bit          INIT_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic switch_in,
  output logic switch_out,
  output logic switch_rise,
  output logic switch_fall
);

  localparam int unsigned CNT_W = $clog2(BOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_lvl_c;
  logic                   settle_c;
  db_state_e              state_c;

  assign sync_d     = {sync_q[SYNC_STAGES-2:0], switch_in};
  assign sync_lvl_c = sync_q[SYNC_STAGES-1];
  assign state_c    = (cnt_q == '0) ? DB_STABLE : DB_COUNTING;

  // Next-state: any agreement clears the count, so bounce time never accumulates
  always_comb begin
    cnt_d    = '0;
    out_d    = out_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    settle_c = 1'b0;
    unique case (state_c)
      DB_STABLE: begin
        if (sync_lvl_c != out_q) begin
          if (CNT_LAST == '0) settle_c = 1'b1;
          else                cnt_d    = CNT_W'(1);
        end
      end
      DB_COUNTING: begin
        if (sync_lvl_c != out_q) begin
          if (cnt_q == CNT_LAST) settle_c = 1'b1;
          else                   cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
    if (settle_c) begin
      out_d  = sync_lvl_c;
      rise_d = sync_lvl_c;
      fall_d = ~sync_lvl_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
      cnt_q  <= '0;
      out_q  <= INIT_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign switch_out  = out_q;
  assign switch_rise = rise_q;
  assign switch_fall = fall_q;

endmodule : debounce_channel

// File: rtl/input_debounce.sv
// Multi-channel synchronizer/debouncer for mechanical inputs; one independent channel per bit.
module input_debounce #(
  parameter int unsigned WIDTH        = 2,
  parameter int unsigned BOUNCE_LIMIT = 300000,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter bit          INIT_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] switch_in,
  output logic [WIDTH-1:0] switch_out,
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall
);

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_ch
    debounce_channel #(
      .BOUNCE_LIMIT(BOUNCE_LIMIT),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .switch_in  (switch_in[g]),
      .switch_out (switch_out[g]),
      .switch_rise(switch_rise[g]),
      .switch_fall(switch_fall[g])
    );
  end

endmodule : input_debounce

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with WIDTH=2, SYNC_STAGES=2, BOUNCE_LIMIT=4, INIT_LEVEL=0.
module tb_input_debounce;

  logic       clk;
  logic       reset;
  logic [1:0] switch_in;
  logic [1:0] switch_out;
  logic [1:0] switch_rise;
  logic [1:0] switch_fall;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic       rst;
    logic [1:0] sw;
    logic [1:0] exp_out;
    logic [1:0] exp_rise;
    logic [1:0] exp_fall;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  input_debounce #(
    .WIDTH       (2),
    .BOUNCE_LIMIT(4),
    .SYNC_STAGES (2),
    .INIT_LEVEL  (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .switch_in  (switch_in),
    .switch_out (switch_out),
    .switch_rise(switch_rise),
    .switch_fall(switch_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [1:0] sw, input logic [1:0] eo,
                     input logic [1:0] er, input logic [1:0] ef, input string tag);
    vec_t v;
    v.rst = r; v.sw = sw; v.exp_out = eo; v.exp_rise = er; v.exp_fall = ef; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag, input string sig, input logic [1:0] act,
                       input logic [1:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s.%s @%0t: got %b expected %b", tag, sig, $time, act, exp);
    end
  endtask

  // Apply inputs for one edge, then compare all three outputs just after it
  task automatic step(input logic r, input logic [1:0] sw, input logic [1:0] eo,
                      input logic [1:0] er, input logic [1:0] ef, input string tag);
    reset     = r;
    switch_in = sw;
    @(posedge clk);
    #1;
    n_vec++;
    check(tag, "out",  switch_out,  eo);
    check(tag, "rise", switch_rise, er);
    check(tag, "fall", switch_fall, ef);
  endtask

  initial begin
    reset     = 1'b1;
    switch_in = 2'b00;

    // Reset with pins high, then release: rise on both at the 6th edge counting the first sample edge
    for (int i = 0; i < 3; i++) add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, "reset_hold");
    for (int j = 0; j < 5; j++) add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, "reset_release");
    add(1'b0, 2'b11, 2'b11, 2'b11, 2'b00, "reset_rise");
    add(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, "reset_rise_end");

    // Simultaneous fall from settled 11
    for (int j = 0; j < 5; j++) add(1'b0, 2'b00, 2'b11, 2'b00, 2'b00, "sim_fall_wait");
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, "sim_fall");
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "sim_fall_end");

    // Clean step on ch0, ch1 untouched, then back down
    for (int j = 0; j < 5; j++) add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, "step_wait");
    add(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, "step_rise");
    add(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, "step_hold");
    for (int j = 0; j < 5; j++) add(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, "step_down_wait");
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, "step_fall");
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "step_quiet");

    // Glitch of BOUNCE_LIMIT-1 cycles is dropped
    for (int j = 0; j < 3; j++) add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, "glitch3_hi");
    for (int j = 0; j < 6; j++) add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "glitch3_lo");

    // Pulse of exactly BOUNCE_LIMIT cycles passes, and so does its falling edge
    for (int j = 0; j < 4; j++) add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, "pulse4_hi");
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "pulse4_lo");
    add(1'b0, 2'b00, 2'b01, 2'b01, 2'b00, "pulse4_rise");
    for (int j = 0; j < 3; j++) add(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, "pulse4_held");
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, "pulse4_fall");
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "pulse4_end");

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].sw, vecs[i].exp_out, vecs[i].exp_rise, vecs[i].exp_fall, vecs[i].tag);

    // Bounce train on ch1: toggles every 2 cycles, then held high
    for (int c = 0; c < 20; c++)
      step(1'b0, (((c / 2) % 2) == 0) ? 2'b10 : 2'b00, 2'b00, 2'b00, 2'b00, "bounce_train");
    for (int j = 0; j < 8; j++)
      step(1'b0, 2'b10, (j >= 5) ? 2'b10 : 2'b00, (j == 5) ? 2'b10 : 2'b00, 2'b00, "bounce_settle");

    // Return ch1 low before the mid-count reset case
    for (int j = 0; j < 7; j++)
      step(1'b0, 2'b00, (j >= 5) ? 2'b00 : 2'b10, 2'b00, (j == 5) ? 2'b10 : 2'b00, "bounce_release");

    // Mid-count reset: two counts pending on ch0, reset wipes them
    for (int j = 0; j < 4; j++) step(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, "midrst_count");
    for (int j = 0; j < 2; j++) step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, "midrst_hold");
    for (int j = 0; j < 7; j++)
      step(1'b0, 2'b01, (j >= 5) ? 2'b01 : 2'b00, (j == 5) ? 2'b01 : 2'b00, 2'b00, "midrst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_input_debounce
